// File: rtl/mips_pkg.sv
// Shared MIPS-1 pipeline types: datapath word, register index, control bundle
// and the forwarding-source encoding used by the operand bypass muxes.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;
  localparam int MIPS_CTRL_W = 16;

  typedef logic [MIPS_DATA_W-1:0] word_t;
  typedef logic [MIPS_ADDR_W-1:0] reg_addr_t;
  typedef logic [MIPS_CTRL_W-1:0] ctrl_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_src_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Single-operand select: $0 forcing, EX/MEM/WB producer match flags and,
// when BYPASS_EN is defined, the forwarding mux (EX > MEM > WB > regfile).
module operand_bypass_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              ex_hit,
  output logic              mem_hit,
  output logic              wb_hit
);

  logic nonzero;

  // $0 never matches a producer, so writes to it can neither forward nor stall
  assign nonzero = |addr;
  assign ex_hit  = ex_we  & nonzero & (ex_addr  == addr);
  assign mem_hit = mem_we & nonzero & (mem_addr == addr);
  assign wb_hit  = wb_we  & nonzero & (wb_addr  == addr);

`ifdef BYPASS_EN
  fwd_src_e src;

  always_comb begin
    src = FWD_RF;
    if (ex_hit)       src = FWD_EX;
    else if (mem_hit) src = FWD_MEM;
    else if (wb_hit)  src = FWD_WB;
  end

  always_comb begin
    data = '0;
    if (nonzero) begin
      case (src)
        FWD_EX:  data = ex_data;
        FWD_MEM: data = mem_data;
        FWD_WB:  data = wb_data;
        default: data = rf_data;
      endcase
    end
  end
`else
  logic unused_fwd_data;

  assign unused_fwd_data = ^{ex_data, mem_data, wb_data};
  assign data = nonzero ? rf_data : '0;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: hazard-resolved operands registered under valid/ready
// with stall and flush. Define BYPASS_EN to forward from EX/MEM/WB producers.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              ex_load_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_rs_data_o,
  output logic [DATA_W-1:0] out_rt_data_o,
  output logic [ADDR_W-1:0] out_rd_addr_o,
  output logic              out_reg_write_o,
  output logic              out_mem_read_o,
  output logic [DATA_W-1:0] out_imm_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [DATA_W-1:0] rs_sel_p0, rt_sel_p0;
  logic              rs_ex_hit, rs_mem_hit, rs_wb_hit;
  logic              rt_ex_hit, rt_mem_hit, rt_wb_hit;
  logic              hazard, advance, accept;

  logic              vld_p1;
  logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1;
  logic [ADDR_W-1:0] rd_addr_p1;
  logic              reg_write_p1, mem_read_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CNT_W-1:0]  stall_cnt;

  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
    .addr(rs_addr_i), .rf_data(rs_data_i),
    .ex_we(ex_we_i), .ex_addr(ex_addr_i), .ex_data(ex_data_i),
    .mem_we(mem_we_i), .mem_addr(mem_addr_i), .mem_data(mem_data_i),
    .wb_we(wb_we_i), .wb_addr(wb_addr_i), .wb_data(wb_data_i),
    .data(rs_sel_p0), .ex_hit(rs_ex_hit), .mem_hit(rs_mem_hit), .wb_hit(rs_wb_hit)
  );

  operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
    .addr(rt_addr_i), .rf_data(rt_data_i),
    .ex_we(ex_we_i), .ex_addr(ex_addr_i), .ex_data(ex_data_i),
    .mem_we(mem_we_i), .mem_addr(mem_addr_i), .mem_data(mem_data_i),
    .wb_we(wb_we_i), .wb_addr(wb_addr_i), .wb_data(wb_data_i),
    .data(rt_sel_p0), .ex_hit(rt_ex_hit), .mem_hit(rt_mem_hit), .wb_hit(rt_wb_hit)
  );

`ifdef BYPASS_EN
  logic unused_late_hits;

  // Only a load still in EX cannot be forwarded; one bubble lets it reach MEM
  assign unused_late_hits = ^{rs_mem_hit, rs_wb_hit, rt_mem_hit, rt_wb_hit};
  assign hazard = in_valid_i & ex_load_i & (rs_ex_hit | rt_ex_hit);
`else
  logic unused_ex_load;

  // Without forwarding, wait until every in-flight producer has retired
  assign unused_ex_load = ex_load_i;
  assign hazard = in_valid_i & (rs_ex_hit | rs_mem_hit | rs_wb_hit |
                                rt_ex_hit | rt_mem_hit | rt_wb_hit);
`endif

  assign advance    = !vld_p1 | out_ready_i;
  assign in_ready_o = advance & !hazard & !flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // ---- ID/EX register (p0 -> p1) ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1       <= 1'b0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      rd_addr_p1   <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      imm_p1       <= '0;
      ctrl_p1      <= '0;
      stall_cnt    <= '0;
    end else begin
      if (flush_i)      vld_p1 <= 1'b0;
      else if (advance) vld_p1 <= in_valid_i & !hazard;
      if (accept) begin
        rs_data_p1   <= rs_sel_p0;
        rt_data_p1   <= rt_sel_p0;
        rd_addr_p1   <= rd_addr_i;
        reg_write_p1 <= reg_write_i;
        mem_read_p1  <= mem_read_i;
        imm_p1       <= imm_i;
        ctrl_p1      <= ctrl_i;
      end
      if (hazard && !flush_i) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_valid_o     = vld_p1;
  assign out_rs_data_o   = rs_data_p1;
  assign out_rt_data_o   = rt_data_p1;
  assign out_rd_addr_o   = rd_addr_p1;
  assign out_reg_write_o = reg_write_p1;
  assign out_mem_read_o  = mem_read_p1;
  assign out_imm_o       = imm_p1;
  assign out_ctrl_o      = ctrl_p1;
  assign stall_cnt_o     = stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow BYPASS_EN when defined.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data, imm;
  logic        reg_write, mem_read;
  logic [15:0] ctrl;
  logic        ex_we, ex_load, mem_we, wb_we;
  logic [4:0]  ex_addr, mem_addr, wb_addr;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_rs, out_rt, out_imm;
  logic [4:0]  out_rd;
  logic        out_rw, out_mr;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_i(rs_data), .rt_data_i(rt_data),
    .rd_addr_i(rd_addr), .reg_write_i(reg_write), .mem_read_i(mem_read),
    .imm_i(imm), .ctrl_i(ctrl),
    .ex_we_i(ex_we), .ex_addr_i(ex_addr), .ex_data_i(ex_data), .ex_load_i(ex_load),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs_data_o(out_rs), .out_rt_data_o(out_rt),
    .out_rd_addr_o(out_rd), .out_reg_write_o(out_rw), .out_mem_read_o(out_mr),
    .out_imm_o(out_imm), .out_ctrl_o(out_ctrl),
    .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_producers();
    ex_we = 0; ex_load = 0; ex_addr = 0; ex_data = 0;
    mem_we = 0; mem_addr = 0; mem_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [4:0] rd, input logic [31:0] im,
                           input logic [15:0] c);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rs_data = rsd; rt_data = rtd;
    rd_addr = rd; reg_write = 1; mem_read = 0; imm = im; ctrl = c;
  endtask

  initial begin
    rst = 1; in_valid = 0; flush = 0; out_ready = 1;
    rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0; rd_addr = 0;
    reg_write = 0; mem_read = 0; imm = 0; ctrl = 0;
    clear_producers();
    #3;
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_rs", out_rs, 32'd0);
    check("reset_stall", {16'b0, stall_cnt}, 32'd0);
    tick(); tick();
    rst = 0;
    tick();

    // plain accept, no producers
    set_instr(5'd1, 5'd2, 32'h11, 32'h22, 5'd4, 32'h55, 16'hA5A5);
    #1 check("plain_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("plain_valid", {31'b0, out_valid}, 32'd1);
    check("plain_rs", out_rs, 32'h11);
    check("plain_rt", out_rt, 32'h22);
    check("plain_rd", {27'b0, out_rd}, 32'd4);
    check("plain_imm", out_imm, 32'h55);
    check("plain_ctrl", {16'b0, out_ctrl}, 32'hA5A5);

    // EX/MEM/WB all target rs=5
    set_instr(5'd5, 5'd6, 32'h5555, 32'h66, 5'd7, 32'h0, 16'h0001);
    ex_we = 1; ex_addr = 5; ex_data = 32'hDEAD_BEEF;
    mem_we = 1; mem_addr = 5; mem_data = 32'h1111;
    wb_we = 1; wb_addr = 5; wb_data = 32'h2222;
`ifdef BYPASS_EN
    #1 check("prio_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("prio_rs_ex_wins", out_rs, 32'hDEAD_BEEF);
    check("prio_rt", out_rt, 32'h66);
`else
    #1 check("nobyp_prio_ready", {31'b0, in_ready}, 32'd0);
    tick();
    exp_stall++;
    check("nobyp_prio_bubble", {31'b0, out_valid}, 32'd0);
    check("nobyp_prio_stall", {16'b0, stall_cnt}, exp_stall);
    clear_producers();
    tick();
    check("nobyp_prio_rs", out_rs, 32'h5555);
`endif

    // $0 is never forwarded and reads as zero
    clear_producers();
    set_instr(5'd0, 5'd0, 32'h9999, 32'h8888, 5'd1, 32'h0, 16'h0002);
    ex_we = 1; ex_addr = 0; ex_data = 32'h1234;
    #1 check("zero_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("zero_rs", out_rs, 32'd0);
    check("zero_rt", out_rt, 32'd0);
    check("zero_valid", {31'b0, out_valid}, 32'd1);

    // load-use on rt=8
    clear_producers();
    set_instr(5'd1, 5'd8, 32'h11, 32'h8888, 5'd9, 32'h0, 16'h0003);
    ex_we = 1; ex_load = 1; ex_addr = 8; ex_data = 32'hBAD0;
    #1 check("lu_ready", {31'b0, in_ready}, 32'd0);
    tick();
    exp_stall++;
    check("lu_bubble", {31'b0, out_valid}, 32'd0);
    check("lu_stall", {16'b0, stall_cnt}, exp_stall);
    clear_producers();
    mem_we = 1; mem_addr = 8; mem_data = 32'hCAFE;
    wb_we = 1; wb_addr = 8; wb_data = 32'h0BAD;
`ifdef BYPASS_EN
    #1 check("lu_mem_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("lu_rt_mem", out_rt, 32'hCAFE);
`else
    #1 check("nobyp_lu_mem_ready", {31'b0, in_ready}, 32'd0);
    tick();
    exp_stall++;
    check("nobyp_lu_stall2", {16'b0, stall_cnt}, exp_stall);
    clear_producers();
    rt_data = 32'hCAFE;
    tick();
    check("nobyp_lu_rt", out_rt, 32'hCAFE);
`endif
    check("lu_valid", {31'b0, out_valid}, 32'd1);
    check("lu_stall_final", {16'b0, stall_cnt}, exp_stall);

    // backpressure then flush
    clear_producers();
    set_instr(5'd10, 5'd11, 32'hAAAA, 32'hBBBB, 5'd12, 32'h77, 16'h0004);
    tick();
    check("bp_load_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 0;
    set_instr(5'd13, 5'd14, 32'hEEEE, 32'hFFFF, 5'd15, 32'h99, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready_low", {31'b0, in_ready}, 32'd0);
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_rs", out_rs, 32'hAAAA);
      check("bp_hold_ctrl", {16'b0, out_ctrl}, 32'h0004);
    end
    flush = 1;
    #1 check("flush_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("flush_discard_valid", {31'b0, out_valid}, 32'd0);
    check("flush_discard_rs", out_rs, 32'hAAAA);

    // WB producer on rs=3
    set_instr(5'd3, 5'd4, 32'h33, 32'h44, 5'd5, 32'h0, 16'h0006);
    wb_we = 1; wb_addr = 3; wb_data = 32'h77;
`ifdef BYPASS_EN
    #1 check("wb_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("wb_rs_fwd", out_rs, 32'h77);
`else
    #1 check("nobyp_wb_ready", {31'b0, in_ready}, 32'd0);
    tick();
    exp_stall++;
    check("nobyp_wb_bubble", {31'b0, out_valid}, 32'd0);
    clear_producers();
    tick();
    check("nobyp_wb_rs", out_rs, 32'h33);
`endif
    check("wb_valid", {31'b0, out_valid}, 32'd1);
    check("wb_stall", {16'b0, stall_cnt}, exp_stall);

    // asynchronous reset mid-stream
    clear_producers();
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_stall", {16'b0, stall_cnt}, 32'd0);
    check("arst_rs", out_rs, 32'd0);
    check("arst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
